branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor.sv | 106 ++++++++++
 tb/tb_branch_target_predictor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit prediction state per entry,
// combinational fetch-stage lookup and resolved-branch / misprediction counters.
module branch_target_predictor #(
   parameter int NENT = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] if_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_npc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispred,
   input  logic        flush_all,
   output logic [15:0] br_cnt,
   output logic [15:0] mis_cnt
);
   localparam int IW = $clog2(NENT);
   localparam int TW = 30 - IW;

   typedef enum logic [1:0] {NH = 2'b00, NS = 2'b01, TH = 2'b10, TS = 2'b11} bpred_t;

   logic          r_valid [NENT];
   logic [TW-1:0] r_tag   [NENT];
   logic [31:0]   r_tgt   [NENT];
   bpred_t        r_st    [NENT];
   logic [15:0]   r_br;
   logic [15:0]   r_mis;

   logic [IW-1:0] w_lidx, w_uidx;
   logic [TW-1:0] w_ltag, w_utag;
   logic          w_uhit;

   // Taken walks NH->NS->TS->TH; not-taken walks the same ladder backwards.
   function automatic bpred_t f_step(input bpred_t s, input logic t);
      bpred_t n;
      n = s;
      if (t) begin
         case (s)
            NH:      n = NS;
            NS:      n = TS;
            default: n = TH;
         endcase
      end else begin
         case (s)
            TH:      n = TS;
            TS:      n = NS;
            default: n = NH;
         endcase
      end
      return n;
   endfunction

   assign w_lidx = if_pc[IW+1:2];
   assign w_ltag = if_pc[31:IW+2];
   assign w_uidx = upd_pc[IW+1:2];
   assign w_utag = upd_pc[31:IW+2];
   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

   assign pred_hit   = !RST && r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
   assign pred_taken = pred_hit && r_st[w_lidx][1];
   assign pred_npc   = pred_taken ? r_tgt[w_lidx] : if_pc + 32'd4;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NENT; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_tgt[i]   <= '0;
            r_st[i]    <= NH;
         end
      end else if (flush_all) begin
         for (int i = 0; i < NENT; i++) begin
            r_valid[i] <= 1'b0;
            r_st[i]    <= NH;
         end
      end else if (upd_en) begin
         if (w_uhit) begin
            r_st[w_uidx] <= f_step(r_st[w_uidx], upd_taken);
            if (upd_taken) r_tgt[w_uidx] <= upd_target;
         end else if (upd_taken) begin
            r_valid[w_uidx] <= 1'b1;
            r_tag[w_uidx]   <= w_utag;
            r_tgt[w_uidx]   <= upd_target;
            r_st[w_uidx]    <= TS;
         end
      end
   end

   // Counters are independent of flush_all and saturate at all-ones.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_br  <= '0;
         r_mis <= '0;
      end else if (upd_en) begin
         if (r_br != 16'hFFFF) r_br <= r_br + 16'd1;
         if (upd_mispred && r_mis != 16'hFFFF) r_mis <= r_mis + 16'd1;
      end
   end

   assign br_cnt  = r_br;
   assign mis_cnt = r_mis;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: the driver pushes model predictions per cycle, a monitor
// pops them at the falling edge and compares against the DUT outputs.
module tb_branch_target_predictor;
   localparam int NENT = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] if_pc = '0;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_npc;
   logic        upd_en = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_mispred = 1'b0;
   logic        flush_all = 1'b0;
   logic [15:0] br_cnt, mis_cnt;

   branch_target_predictor #(.NENT(NENT)) dut (
      .CLK(CLK), .RST(RST), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispred(upd_mispred),
      .flush_all(flush_all), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic        hit;
      logic        taken;
      logic [31:0] npc;
      logic [15:0] br;
      logic [15:0] mis;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: per-index valid/tag/target and a strength 0..3
   // (0=strong not-taken .. 3=strong taken); predicts taken at strength >= 2.
   bit          m_v   [NENT];
   logic [31:0] m_pc  [NENT];
   logic [31:0] m_tgt [NENT];
   int          m_str [NENT];
   int          m_br, m_mis;

   function automatic int idx(input logic [31:0] pc);
      return int'((pc >> 2) % NENT);
   endfunction

   function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
      return (a >> 2) == (b >> 2);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NENT; i++) begin
         m_v[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_str[i] = 0;
      end
      m_br = 0; m_mis = 0;
   endtask

   task automatic cyc(input logic [31:0] pc, input logic en, input logic [31:0] upc,
                      input logic tk, input logic [31:0] tgt, input logic mp,
                      input logic fl, input logic rst);
      exp_t e;
      int   k;
      @(posedge CLK);
      #1;
      if_pc = pc; upd_en = en; upd_pc = upc; upd_taken = tk;
      upd_target = tgt; upd_mispred = mp; flush_all = fl; RST = rst;
      if (rst) m_reset();
      k = idx(pc);
      e.pc    = pc;
      e.hit   = m_v[k] && same_line(m_pc[k], pc);
      e.taken = e.hit && (m_str[k] >= 2);
      e.npc   = e.taken ? m_tgt[k] : pc + 32'd4;
      e.br    = 16'(m_br);
      e.mis   = 16'(m_mis);
      q.push_back(e);
      if (!rst) begin
         k = idx(upc);
         if (fl) begin
            for (int i = 0; i < NENT; i++) begin m_v[i] = 0; m_str[i] = 0; end
         end else if (en) begin
            if (m_v[k] && same_line(m_pc[k], upc)) begin
               if (tk) begin
                  m_str[k] = (m_str[k] < 3) ? m_str[k] + 1 : 3;
                  m_tgt[k] = tgt;
               end else begin
                  m_str[k] = (m_str[k] > 0) ? m_str[k] - 1 : 0;
               end
            end else if (tk) begin
               m_v[k] = 1; m_pc[k] = upc; m_tgt[k] = tgt; m_str[k] = 2;
            end
         end
         if (en) begin
            if (m_br < 65535) m_br++;
            if (mp && m_mis < 65535) m_mis++;
         end
      end
   endtask

   task automatic look(input logic [31:0] pc);
      cyc(pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      cyc(pc, 1'b1, pc, tk, tgt, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [31:0] pc,
                      input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s pc=%08h got=%08h want=%08h", nm, pc, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("hit",   e.pc, 32'(pred_hit),   32'(e.hit));
            chk("taken", e.pc, 32'(pred_taken), 32'(e.taken));
            chk("npc",   e.pc, pred_npc,        e.npc);
            chk("br",    e.pc, 32'(br_cnt),     32'(e.br));
            chk("mis",   e.pc, 32'(mis_cnt),    32'(e.mis));
         end
      end
   end

   initial begin : driver
      logic [31:0] pc, upc;
      m_reset();
      cyc(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      cyc(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      look(32'h40);
      // Same-index lookup during update sees pre-edge contents.
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      look(32'h40);
      upd(32'h40, 1'b1, 32'h100);
      look(32'h43);
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40);
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40);
      upd(32'h80, 1'b1, 32'h200);
      look(32'h40);
      look(32'h80);
      cyc(32'h80, 1'b1, 32'h10, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
      look(32'h80);
      look(32'h10);
      look(32'hFFFFFFFC);
      // Randomized phase over a small address pool to force aliasing.
      for (int n = 0; n < 600; n++) begin
         pc  = {$urandom_range(0, 2) == 0 ? 26'h3FFFFFF : 26'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         upc = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         cyc(pc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 2) != 0),
             $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, 1'b0);
      end
      // Reset abandons an in-flight update.
      cyc(32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
      look(32'h40);
      // Counter saturation: drive br_cnt to FFFE, then three mispredicts.
      for (int n = 0; n < 65534; n++)
         cyc(32'h40, 1'b1, 32'h1000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++)
         cyc(32'h40, 1'b1, 32'h1000, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      look(32'h40);
      cyc(32'h40, 1'b1, 32'h1000, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      cyc(32'h40, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      look(32'h40);
      @(posedge CLK);
      @(posedge CLK);
      chk("drain", 32'h0, 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
